rto_core_param: RTL and testbench

// - Parametrised real-time output core: buffers {timestamp,data} events, issues each on rto_out the cycle after the

---
 rtl/rto_pkg.sv | 13 +
 rtl/rto_sync_fifo.sv | 82 ++++++++
 rtl/rto_core_param.sv | 139 +++++++++++++
 tb/tb_rto_core_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rto_pkg.sv
// Shared constants and helpers for the real-time output core.
package rto_pkg;

    localparam int LATE_DROP  = 0;
    localparam int LATE_ISSUE = 1;
    localparam int CNT_W      = 16;

    // Saturating increment for the optional error counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rto_sync_fifo.sv
// First-word-fall-through synchronous FIFO: inferred RAM with registered read
// feeding the head register, programmable full threshold, sync clear on flush.
module rto_sync_fifo
#(
    parameter int WIDTH       = 128,
    parameter int DEPTH       = 8192,
    parameter int FULL_MARGIN = 92
)
(
    input  logic             clk,
    input  logic             srst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_THRESH = CW'(DEPTH - FULL_MARGIN);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_head;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_head_valid;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic [CW-1:0]    w_mem_cnt;
    logic [CW-1:0]    w_count_next;

    assign w_push       = i_wr_en && !r_full && !i_flush;
    assign w_pop        = i_rd_en && r_head_valid;
    // r_count includes the head entry; what remains in RAM is everything else.
    assign w_mem_cnt    = r_count - CW'(r_head_valid);
    assign w_load       = (w_mem_cnt != '0) && (!r_head_valid || w_pop);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_head <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count      <= w_count_next;
            r_head_valid <= w_load ? 1'b1 : (w_pop ? 1'b0 : r_head_valid);
            r_full       <= (w_count_next >= FULL_THRESH);
        end
    end

    assign o_dout  = r_head;
    assign o_valid = r_head_valid;
    assign o_full  = r_full;

endmodule

// File: rtl/rto_core_param.sv
// Real-time output core: issues buffered {timestamp,data} events when the system
// counter reaches their timestamp. RTO_CORE_ERR_CNT_EN adds saturating error counters.
module rto_core_param
    import rto_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int TS_W        = 64,
    parameter int DEPTH       = 8192,
    parameter int FULL_MARGIN = 92,
    parameter int LATE_POLICY = LATE_DROP
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   auto_start,
    input  logic                   flush,
    input  logic                   write,
    input  logic [TS_W+DATA_W-1:0] fifo_din,
    input  logic [TS_W-1:0]        counter,
    output logic [DATA_W-1:0]      rto_out,
    output logic                   counter_matched,
    output logic                   timestamp_error,
    output logic [TS_W+DATA_W-1:0] timestamp_error_data,
    output logic                   overflow_error,
    output logic [TS_W+DATA_W-1:0] overflow_error_data,
    output logic                   full,
    output logic                   empty
`ifdef RTO_CORE_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]       overflow_count,
    output logic [CNT_W-1:0]       late_count
`endif
);

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] data;
    } rto_entry_t;

    rto_entry_t w_head;
    logic       w_head_valid;
    logic       w_full;
    logic       w_armed;
    logic       w_match;
    logic       w_late;
    logic       w_pop;
    logic       w_issue;
    logic       w_ovf;

    logic [DATA_W-1:0]      r_rto_out;
    logic                   r_matched;
    logic                   r_ts_err;
    logic [TS_W+DATA_W-1:0] r_ts_err_data;
    logic                   r_ovf;
    logic [TS_W+DATA_W-1:0] r_ovf_data;

    rto_sync_fifo #(
        .WIDTH       (TS_W + DATA_W),
        .DEPTH       (DEPTH),
        .FULL_MARGIN (FULL_MARGIN)
    ) u_fifo (
        .clk     (clk),
        .srst    (reset),
        .i_flush (flush),
        .i_wr_en (write),
        .i_din   (fifo_din),
        .i_rd_en (w_pop),
        .o_dout  (w_head),
        .o_valid (w_head_valid),
        .o_full  (w_full)
    );

    // Timestamps compare as plain unsigned values; the counter is not expected to wrap.
    assign w_armed = w_head_valid && auto_start;
    assign w_match = w_armed && (w_head.ts == counter);
    assign w_late  = w_armed && (w_head.ts < counter);
    assign w_pop   = w_match || w_late;
    assign w_issue = w_match || (w_late && (LATE_POLICY == LATE_ISSUE));
    assign w_ovf   = write && w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rto_out     <= '0;
            r_matched     <= 1'b0;
            r_ts_err      <= 1'b0;
            r_ts_err_data <= '0;
            r_ovf         <= 1'b0;
            r_ovf_data    <= '0;
        end else begin
            r_matched <= w_issue;
            r_ts_err  <= w_late;
            r_ovf     <= w_ovf;
            if (w_issue) begin
                r_rto_out <= w_head.data;
            end
            if (w_late) begin
                r_ts_err_data <= w_head;
            end
            if (w_ovf) begin
                r_ovf_data <= fifo_din;
            end
        end
    end

    assign rto_out              = r_rto_out;
    assign counter_matched      = r_matched;
    assign timestamp_error      = r_ts_err;
    assign timestamp_error_data = r_ts_err_data;
    assign overflow_error       = r_ovf;
    assign overflow_error_data  = r_ovf_data;
    assign full                 = w_full;
    assign empty                = !w_head_valid;

`ifdef RTO_CORE_ERR_CNT_EN
    // Index 0 counts rejected writes, index 1 counts late heads; flush leaves them alone.
    logic [1:0]       w_cnt_inc;
    logic [CNT_W-1:0] w_cnt [2];

    assign w_cnt_inc = {w_late, w_ovf};

    for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_cnt_inc[gi]) begin
                r_cnt <= sat_inc(r_cnt);
            end
        end

        assign w_cnt[gi] = r_cnt;
    end

    assign overflow_count = w_cnt[0];
    assign late_count     = w_cnt[1];
`endif

endmodule

// File: tb/tb_rto_core_param.sv
// Bench for rto_core_param: one instance per late policy, driven with directed and
// $urandom stimulus and compared every cycle against a queue-based event model.
module tb_rto_core_param;

    localparam int DW     = 32;
    localparam int TW     = 32;
    localparam int DEPTH  = 32;
    localparam int MARGIN = 4;
    localparam int THRESH = DEPTH - MARGIN;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          auto_start = 1'b1;
    logic          flush = 1'b0;
    logic          write = 1'b0;
    logic [63:0]   fifo_din = '0;
    logic [31:0]   counter = 32'd0;

    logic [31:0]   rto_out0, rto_out1;
    logic          matched0, matched1, terr0, terr1, ovf0, ovf1;
    logic [63:0]   terr_data0, terr_data1, ovf_data0, ovf_data1;
    logic          full0, full1, empty0, empty1;
`ifdef RTO_CORE_ERR_CNT_EN
    logic [15:0]   ovf_cnt0, ovf_cnt1, late_cnt0, late_cnt1;
`endif

    always #5 clk = ~clk;

    rto_core_param #(.DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH), .FULL_MARGIN(MARGIN), .LATE_POLICY(0)) dut0 (
        .clk(clk), .reset(reset), .auto_start(auto_start), .flush(flush), .write(write),
        .fifo_din(fifo_din), .counter(counter), .rto_out(rto_out0), .counter_matched(matched0),
        .timestamp_error(terr0), .timestamp_error_data(terr_data0), .overflow_error(ovf0),
        .overflow_error_data(ovf_data0), .full(full0), .empty(empty0)
`ifdef RTO_CORE_ERR_CNT_EN
        , .overflow_count(ovf_cnt0), .late_count(late_cnt0)
`endif
    );

    rto_core_param #(.DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH), .FULL_MARGIN(MARGIN), .LATE_POLICY(1)) dut1 (
        .clk(clk), .reset(reset), .auto_start(auto_start), .flush(flush), .write(write),
        .fifo_din(fifo_din), .counter(counter), .rto_out(rto_out1), .counter_matched(matched1),
        .timestamp_error(terr1), .timestamp_error_data(terr_data1), .overflow_error(ovf1),
        .overflow_error_data(ovf_data1), .full(full1), .empty(empty1)
`ifdef RTO_CORE_ERR_CNT_EN
        , .overflow_count(ovf_cnt1), .late_count(late_cnt1)
`endif
    );

    // Model: each queued event carries the earliest cycle it may be at the FIFO head.
    typedef struct {
        logic [63:0] ent;
        int          avail;
    } qe_t;

    qe_t         q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_rto0 = '0, exp_rto1 = '0;
    logic        exp_m0 = 0, exp_m1 = 0, exp_te = 0, exp_ovf = 0, exp_full = 0, exp_empty = 1;
    logic [63:0] exp_te_data = '0, exp_ovf_data = '0;
    logic [15:0] exp_ovf_cnt = '0, exp_late_cnt = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d: observed %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        bit          full_start;
        bit          popped = 0;
        logic [31:0] hts;
        logic [31:0] hdata;
        qe_t         ne;
        @(posedge clk);
        if (reset) begin
            q.delete();
            {exp_rto0, exp_rto1, exp_m0, exp_m1, exp_te, exp_ovf, exp_full} = '0;
            exp_te_data  = '0;
            exp_ovf_data = '0;
            exp_ovf_cnt  = '0;
            exp_late_cnt = '0;
        end else begin
            full_start = (q.size() >= THRESH);
            {exp_m0, exp_m1, exp_te, exp_ovf} = '0;
            if (auto_start && q.size() > 0 && q[0].avail <= cyc) begin
                hts   = q[0].ent[63:32];
                hdata = q[0].ent[31:0];
                if (hts == counter) begin
                    popped = 1;
                    exp_m0 = 1; exp_m1 = 1;
                    exp_rto0 = hdata; exp_rto1 = hdata;
                    $display("cyc %0d issue ts=%0d data=%h", cyc, hts, hdata);
                end else if (hts < counter) begin
                    popped = 1;
                    exp_te = 1; exp_te_data = q[0].ent;
                    exp_m1 = 1; exp_rto1 = hdata;
                    if (exp_late_cnt != 16'hFFFF) exp_late_cnt++;
                    $display("cyc %0d late  ts=%0d counter=%0d data=%h", cyc, hts, counter, hdata);
                end
            end
            if (popped) begin
                void'(q.pop_front());
                if (q.size() > 0 && q[0].avail < cyc + 1) q[0].avail = cyc + 1;
            end
            if (write && full_start) begin
                exp_ovf = 1;
                exp_ovf_data = fifo_din;
                if (exp_ovf_cnt != 16'hFFFF) exp_ovf_cnt++;
                $display("cyc %0d overflow din=%h", cyc, fifo_din);
            end
            if (flush) begin
                q.delete();
            end else if (write && !full_start) begin
                ne.ent = fifo_din;
                ne.avail = cyc + 2;
                q.push_back(ne);
            end
            exp_full = (q.size() >= THRESH);
        end
        cyc++;
        exp_empty = !(q.size() > 0 && q[0].avail <= cyc);
        #1;
        check("rto_out_p0", 64'(rto_out0), 64'(exp_rto0));
        check("rto_out_p1", 64'(rto_out1), 64'(exp_rto1));
        check("matched_p0", 64'(matched0), 64'(exp_m0));
        check("matched_p1", 64'(matched1), 64'(exp_m1));
        check("ts_err_p0", 64'(terr0), 64'(exp_te));
        check("ts_err_p1", 64'(terr1), 64'(exp_te));
        check("ts_err_data_p0", terr_data0, exp_te_data);
        check("ts_err_data_p1", terr_data1, exp_te_data);
        check("ovf_p0", 64'(ovf0), 64'(exp_ovf));
        check("ovf_p1", 64'(ovf1), 64'(exp_ovf));
        check("ovf_data_p0", ovf_data0, exp_ovf_data);
        check("ovf_data_p1", ovf_data1, exp_ovf_data);
        check("full_p0", 64'(full0), 64'(exp_full));
        check("full_p1", 64'(full1), 64'(exp_full));
        check("empty_p0", 64'(empty0), 64'(exp_empty));
        check("empty_p1", 64'(empty1), 64'(exp_empty));
`ifdef RTO_CORE_ERR_CNT_EN
        check("ovf_cnt_p0", 64'(ovf_cnt0), 64'(exp_ovf_cnt));
        check("ovf_cnt_p1", 64'(ovf_cnt1), 64'(exp_ovf_cnt));
        check("late_cnt_p0", 64'(late_cnt0), 64'(exp_late_cnt));
        check("late_cnt_p1", 64'(late_cnt1), 64'(exp_late_cnt));
`endif
        counter = counter + 32'd1;
    endtask

    task automatic push(input logic [31:0] ts, input logic [31:0] data);
        write = 1'b1;
        fifo_din = {ts, data};
        step();
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset with a write pending: reset must dominate.
        write = 1'b1;
        fifo_din = {32'd5, 32'h1111_1111};
        idle(3);
        write = 1'b0;
        reset = 1'b0;
        idle(2);

        // Consecutive timestamps issue on consecutive cycles.
        counter = 32'd90;
        push(32'd100, 32'hA);
        push(32'd101, 32'hB);
        push(32'd102, 32'hC);
        push(32'd103, 32'hD);
        idle(16);

        // Late head: dropped by policy 0, issued by policy 1.
        counter = 32'd60;
        push(32'd50, 32'hDEAD_BEEF);
        idle(6);

        // Fill past the margin threshold, then reject writes.
        counter = 32'd1000;
        for (int i = 0; i < THRESH + 2; i++) push(32'hF000_0000 + i, 32'h5000 + i);
        idle(2);
        push(32'hF100_0000, 32'h0BAD_0001);
        push(32'hF100_0001, 32'h0BAD_0002);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle(3);

        // Future events flushed away; error data retained.
        for (int i = 0; i < 10; i++) push(counter + 32'd100 + i, 32'h7000 + i);
        flush = 1'b1;
        push(counter + 32'd5, 32'h7777);
        flush = 1'b0;
        idle(4);

        // auto_start held low: entries retained, then released late.
        for (int i = 0; i < 4; i++) push(counter + 32'd6 + i, 32'h9000 + i);
        auto_start = 1'b0;
        idle(12);
        auto_start = 1'b1;
        idle(6);

        // Randomised traffic.
        for (int i = 0; i < 700; i++) begin
            write      = ($urandom_range(0, 2) == 0);
            fifo_din   = {counter + $urandom_range(0, 14) - 32'd3, 32'($urandom)};
            flush      = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) auto_start = ~auto_start;
            step();
        end
        write = 1'b0;
        flush = 1'b0;
        auto_start = 1'b1;
        idle(4);

        // Reset mid-stream clears everything.
        for (int i = 0; i < 5; i++) push(counter + 32'd50 + i, 32'hC000 + i);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
